// File: rtl/serializer.sv
// Parallel-to-serial shifter for the UART TX path, LSB first by default.
// Define SER_MSB_FIRST_EN to send the MSB first instead.
module serializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  ser_en,
  output logic                  ser_data,
  output logic                  ser_done,
  output logic                  busy
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] sreg;
  logic [CW-1:0]         cnt;
  logic                  ser_en_q;
  logic                  start;

  assign start = ser_en & ~ser_en_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sreg     <= '0;
      cnt      <= '0;
      ser_en_q <= 1'b0;
      ser_data <= 1'b0;
      ser_done <= 1'b0;
      busy     <= 1'b0;
    end else begin
      ser_en_q <= ser_en;
      unique case (state)
        IDLE: begin
          ser_done <= 1'b0;
          if (start) begin
            sreg  <= P_DATA;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
`ifdef SER_MSB_FIRST_EN
            ser_data <= P_DATA[DATA_WIDTH-1];
`else
            ser_data <= P_DATA[0];
`endif
          end else begin
            ser_data <= 1'b0;
            busy     <= 1'b0;
          end
        end
        SHIFT: begin
          if (!ser_en) begin
            // abort: drop the frame without a done pulse
            ser_data <= 1'b0;
            busy     <= 1'b0;
            state    <= IDLE;
          end else if (cnt != LAST) begin
            cnt <= cnt + 1'b1;
`ifdef SER_MSB_FIRST_EN
            sreg     <= sreg << 1;
            ser_data <= sreg[DATA_WIDTH-2];
`else
            sreg     <= sreg >> 1;
            ser_data <= sreg[1];
`endif
          end else begin
            ser_data <= 1'b0;
            busy     <= 1'b0;
            ser_done <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          ser_done <= 1'b0;
          ser_data <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state    <= IDLE;
          ser_data <= 1'b0;
          ser_done <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serializer.sv
// Directed self-checking bench for serializer (DATA_WIDTH=8).
// Expected bit sequences are written in send order, first bit leftmost.
module tb_serializer;

  logic       clk;
  logic       rst;
  logic [7:0] P_DATA;
  logic       ser_en;
  logic       ser_data;
  logic       ser_done;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  serializer #(.DATA_WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .P_DATA   (P_DATA),
    .ser_en   (ser_en),
    .ser_data (ser_data),
    .ser_done (ser_done),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // seq[7] is the first bit on the line, seq[0] the last
  task automatic frame(input string tag,
                       input logic [7:0] seq,
                       input bit scramble);
    for (int k = 0; k < 8; k++) begin
      tick();
      check($sformatf("%s bit%0d", tag, k), ser_data, seq[7-k]);
      check($sformatf("%s busy%0d", tag, k), busy, 1'b1);
      check($sformatf("%s nodone%0d", tag, k), ser_done, 1'b0);
      if (scramble && k == 0) P_DATA = 8'h00;
    end
    tick();
    check({tag, " done"}, ser_done, 1'b1);
    check({tag, " done_data"}, ser_data, 1'b0);
    check({tag, " done_busy"}, busy, 1'b0);
    tick();
    check({tag, " done_clr"}, ser_done, 1'b0);
    check({tag, " idle_busy"}, busy, 1'b0);
    tick();
    check({tag, " norestart_busy"}, busy, 1'b0);
    check({tag, " norestart_data"}, ser_data, 1'b0);
    check({tag, " norestart_done"}, ser_done, 1'b0);
  endtask

  logic [7:0] seq_8f;
  logic [7:0] seq_9e;
  logic [7:0] seq_a5;

  initial begin
`ifdef SER_MSB_FIRST_EN
    seq_8f = 8'b1000_1111;
    seq_9e = 8'b1001_1110;
    seq_a5 = 8'b1010_0101;
`else
    seq_8f = 8'b1111_0001;
    seq_9e = 8'b0111_1001;
    seq_a5 = 8'b1010_0101;
`endif
    rst    = 1'b1;
    ser_en = 1'b1;
    P_DATA = 8'hFF;
    tick();
    tick();
    check("rst data", ser_data, 1'b0);
    check("rst done", ser_done, 1'b0);
    check("rst busy", busy, 1'b0);
    rst    = 1'b0;
    ser_en = 1'b0;
    tick();
    check("idle busy", busy, 1'b0);

    P_DATA = 8'h8F;
    ser_en = 1'b1;
    frame("f8f", seq_8f, 1'b0);

    ser_en = 1'b0;
    tick();
    P_DATA = 8'h9E;
    ser_en = 1'b1;
    frame("f9e", seq_9e, 1'b0);

    ser_en = 1'b0;
    tick();
    P_DATA = 8'hA5;
    ser_en = 1'b1;
    frame("fa5", seq_a5, 1'b1);

    ser_en = 1'b0;
    tick();
    P_DATA = 8'hFF;
    ser_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("abort bit%0d", k), ser_data, 1'b1);
      check($sformatf("abort busy%0d", k), busy, 1'b1);
    end
    ser_en = 1'b0;
    tick();
    check("abort data", ser_data, 1'b0);
    check("abort busy", busy, 1'b0);
    check("abort nodone", ser_done, 1'b0);
    tick();
    check("abort nodone2", ser_done, 1'b0);
    ser_en = 1'b1;
    frame("fff", 8'hFF, 1'b0);

    // reset in the middle of a frame
    ser_en = 1'b0;
    tick();
    P_DATA = 8'hFF;
    ser_en = 1'b1;
    tick();
    tick();
    check("mid busy", busy, 1'b1);
    rst = 1'b1;
    tick();
    check("midrst data", ser_data, 1'b0);
    check("midrst busy", busy, 1'b0);
    check("midrst done", ser_done, 1'b0);
    rst    = 1'b0;
    ser_en = 1'b0;
    tick();
    check("post busy", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
